// File: rtl/pool_window_scheduler.sv
// pool_window_scheduler
//
// Walks every non-overlapping 2x2 window of a MAP_W x MAP_H feature map in raster
// order, reads the four samples of each window, reduces them to a signed maximum
// and writes one pooled value per window. A one-cycle done pulse ends the pass.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    begin one pass; sampled only while idle
//   busy     high in every state except idle
//   done     one-cycle pulse when the pass completes
//   rd_en    read strobe to the feature-map RAM
//   rd_addr  row-major read address (row*MAP_W+col)
//   rd_data  signed read data, valid one cycle after rd_en
//   wr_en    write strobe to the pooled-map RAM
//   wr_addr  row-major pooled address (r*(MAP_W/2)+c)
//   wr_data  signed pooled value
//
// Build option: define POOL_RELU_EN to clamp negative pooled values to zero at write.
// All outputs are registered; addresses and write data hold while strobes are low.

module pool_window_scheduler #(
  parameter int unsigned DATA_W    = 22,
  parameter int unsigned MAP_W     = 28,
  parameter int unsigned MAP_H     = 28,
  parameter int unsigned RD_ADDR_W = 10,
  parameter int unsigned WR_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [RD_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 wr_en,
  output logic [WR_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]    wr_data
);

  localparam int unsigned HalfW = MAP_W / 2;
  localparam int unsigned HalfH = MAP_H / 2;
  localparam int unsigned CW    = (HalfW > 1) ? $clog2(HalfW) : 1;
  localparam int unsigned RW    = (HalfH > 1) ? $clog2(HalfH) : 1;

  localparam logic [CW-1:0]        CLast  = CW'(HalfW - 1);
  localparam logic [RW-1:0]        RLast  = RW'(HalfH - 1);
  localparam logic [RD_ADDR_W-1:0] MapWA  = RD_ADDR_W'(MAP_W);
  localparam logic [WR_ADDR_W-1:0] HalfWA = WR_ADDR_W'(HalfW);

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [RW-1:0]         r_q, r_d;
  logic [CW-1:0]         c_q, c_d;
  logic [DATA_W-1:0]     max_q, max_d;

  logic                  busy_d, done_d, rd_en_d, wr_en_d;
  logic [RD_ADDR_W-1:0]  rd_addr_d;
  logic [WR_ADDR_W-1:0]  wr_addr_d;
  logic [DATA_W-1:0]     wr_data_d;

  function automatic logic [DATA_W-1:0] pool_out(input logic [DATA_W-1:0] m);
`ifdef POOL_RELU_EN
    return m[DATA_W-1] ? '0 : m;
`else
    return m;
`endif
  endfunction

  // Next state, counters and running maximum.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    r_d     = r_q;
    c_d     = c_q;
    max_d   = max_q;

    // Data in this cycle belongs to the read issued one cycle earlier: in FETCH idx i
    // it is sample i-1, in DRAIN it is sample 3. Sample 0 loads unconditionally.
    if (state_q == StFetch && idx_q == 2'd1) begin
      max_d = rd_data;
    end else if ((state_q == StFetch && idx_q != 2'd0) || state_q == StDrain) begin
      if ($signed(rd_data) > $signed(max_q)) max_d = rd_data;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          idx_d   = '0;
          r_d     = '0;
          c_d     = '0;
        end
      end
      StFetch: begin
        if (idx_q == 2'd3) state_d = StDrain;
        else               idx_d   = idx_q + 2'd1;
      end
      StDrain: state_d = StWrite;
      StWrite: begin
        idx_d = '0;
        if (c_q == CLast) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
        state_d = (r_q == RLast && c_q == CLast) ? StDone : StFetch;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output registers are loaded from the next state so they line up with it.
  always_comb begin
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    rd_en_d   = (state_d == StFetch);
    wr_en_d   = (state_d == StWrite);
    rd_addr_d = rd_addr;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    if (rd_en_d) begin
      rd_addr_d = RD_ADDR_W'({r_d, 1'b0}) * MapWA + RD_ADDR_W'({c_d, 1'b0})
                + (idx_d[1] ? MapWA : '0) + RD_ADDR_W'(idx_d[0]);
    end
    if (wr_en_d) begin
      wr_addr_d = WR_ADDR_W'(r_d) * HalfWA + WR_ADDR_W'(c_d);
      wr_data_d = pool_out(max_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      max_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
      c_q     <= c_d;
      max_q   <= max_d;
      busy    <= busy_d;
      done    <= done_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_pool_window_scheduler.sv
// Testbench for pool_window_scheduler on a 4x4 map. A behavioural RAM serves reads;
// expected pooled values and the cycle schedule come from plain arithmetic on the map.
module tb_pool_window_scheduler;

  localparam int DW  = 22;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int RAW = 4;
  localparam int WAW = 2;
  localparam int HW  = W / 2;
  localparam int N   = (W / 2) * (H / 2);
  localparam int SMin = -2097152;
  localparam int SMax = 2097151;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy, done, rd_en, wr_en;
  logic [RAW-1:0] rd_addr;
  logic [DW-1:0]  rd_data = '0;
  logic [WAW-1:0] wr_addr;
  logic [DW-1:0]  wr_data;

  int mem [W*H];
  int errors = 0;
  int checks = 0;

  pool_window_scheduler #(
    .DATA_W(DW), .MAP_W(W), .MAP_H(H), .RD_ADDR_W(RAW), .WR_ADDR_W(WAW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= DW'(mem[rd_addr]);

  function automatic int rnd_sample();
    return int'($urandom_range(0, 4194303)) - 2097152;
  endfunction

  function automatic int model_out(input int j);
    int b, m;
    b = 2 * (j / HW) * W + 2 * (j % HW);
    m = mem[b];
    if (mem[b+1] > m)   m = mem[b+1];
    if (mem[b+W] > m)   m = mem[b+W];
    if (mem[b+W+1] > m) m = mem[b+W+1];
`ifdef POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  // One full pass with cycle-exact checks. Cycle 0 is the cycle start is high.
  task automatic run_pass(input bit pulses, input bit chain, input bit prestarted);
    if (!prestarted) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int k = 1; k <= 6*N + 2; k++) begin
      int  j, ph, exp_addr;
      bit  e_busy, e_done, e_rd, e_wr;
      @(negedge clk);
      start  = (pulses && (k == 3 || k == 10)) || (chain && k == 6*N + 2);
      j      = (k - 1) / 6;
      ph     = (k - 1) % 6;
      e_busy = (k <= 6*N + 1);
      e_done = (k == 6*N + 1);
      e_rd   = (k <= 6*N) && (ph < 4);
      e_wr   = (k <= 6*N) && (ph == 5);
      checks++;
      if ({busy, done, rd_en, wr_en} !== {e_busy, e_done, e_rd, e_wr}) begin
        errors++;
        $display("FAIL strobes cycle %0d: busy/done/rd_en/wr_en got %b%b%b%b want %b%b%b%b",
                 k, busy, done, rd_en, wr_en, e_busy, e_done, e_rd, e_wr);
      end
      if (e_rd) begin
        exp_addr = 2 * (j / HW) * W + 2 * (j % HW) + (ph % 2) + (ph / 2) * W;
        checks++;
        if (int'(rd_addr) != exp_addr) begin
          errors++;
          $display("FAIL rd_addr cycle %0d: got %0d want %0d", k, rd_addr, exp_addr);
        end
      end
      if (e_wr) begin
        checks++;
        if (int'(wr_addr) != j || int'($signed(wr_data)) != model_out(j)) begin
          errors++;
          $display("FAIL write cycle %0d: got addr %0d data %0d want addr %0d data %0d",
                   k, wr_addr, $signed(wr_data), j, model_out(j));
        end
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'b0 || rd_addr !== '0 || wr_addr !== '0 ||
        wr_data !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b rd_en=%b rd_addr=%0d wr_en=%b wr_addr=%0d wr_data=%0d want all 0",
               name, busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_directed();
    for (int i = 0; i < W*H; i++) mem[i] = i - 8;
    run_pass(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_extremes();
    for (int i = 0; i < W*H; i++) mem[i] = rnd_sample();
    mem[0] = SMin; mem[1] = SMax; mem[4] = 0;    mem[5] = -1;
    mem[2] = SMin; mem[3] = SMin; mem[6] = SMin; mem[7] = SMin;
    mem[8] = 9;    mem[9] = 9;    mem[12] = 9;   mem[13] = 9;
    run_pass(1'b0, 1'b0, 1'b0);
  endtask

  // Largest sample placed at each window position in turn.
  task automatic test_position();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < W*H; i++) mem[i] = -int'($urandom_range(1, 1000));
      for (int j = 0; j < N; j++) begin
        int b;
        b = 2 * (j / HW) * W + 2 * (j % HW) + (p % 2) + (p / 2) * W;
        mem[b] = int'($urandom_range(0, 2097151));
      end
      run_pass(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < W*H; i++) mem[i] = rnd_sample();
      run_pass(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Start pulses mid-pass are ignored; a start on the first idle cycle chains a pass.
  task automatic test_back_to_back();
    for (int i = 0; i < W*H; i++) mem[i] = rnd_sample();
    run_pass(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < W*H; i++) mem[i] = rnd_sample();
    run_pass(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < W*H; i++) mem[i] = rnd_sample();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 7 || k == 8) begin
        checks++;
        if (wr_en !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_no_write cycle %0d: wr_en got %b want 0", k, wr_en);
        end
      end
      if (k == 8) rst = 1'b1;
      if (k == 9) begin
        check_all_zero("reset_mid_outputs");
        rst = 1'b0;
      end
    end
    for (int k = 10; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle cycle %0d: wr_en=%b busy=%b rd_en=%b want 0 0 0",
                 k, wr_en, busy, rd_en);
      end
    end
    run_pass(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_extremes();
    test_position();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
